// File: rtl/lsf_sched_pkg.sv
// Shared types and constants for the LSF event scheduler.
// HEG bus lengths are a local copy of the values in l0mdt_buses_constants.svh.
package lsf_sched_pkg;

  localparam int HEG2SFSLC_LEN = 48;
  localparam int HEG2SFHIT_LEN = 40;
  localparam int STAT_W        = 16;
  localparam int N_SRC_MAX     = 8;
  localparam int SRC_IDX_W     = $clog2(N_SRC_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROI,
    S_HITS,
    S_EOF,
    S_WAIT
  } state_e;

endpackage

// File: rtl/lsf_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last pointer, wrapping at N_SRC.
module lsf_rr_arbiter
  import lsf_sched_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0]     req_i,
  input  logic [SRC_IDX_W-1:0] last_i,
  input  logic                 en_i,
  output logic [N_SRC-1:0]     gnt_o,
  output logic [SRC_IDX_W-1:0] idx_o,
  output logic                 vld_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // k walks the priority order; j keeps every bit-select index constant
    for (int k = 1; k <= N_SRC; k++) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (en_i && !found && req_i[j] && (j == (int'(last_i) + k) % N_SRC)) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = SRC_IDX_W'(j);
        end
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/lsf_event_scheduler.sv
// Round-robin scheduler sharing one Legendre segment-finder engine between N_SRC HEG ROI/hit FIFO pairs.
// Optional event/timeout statistics counters are built only when LSF_SCHED_STATS_EN is defined.
module lsf_event_scheduler
  import lsf_sched_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_SRC*HEG2SFSLC_LEN-1:0]   src_roi,
  input  logic [N_SRC-1:0]                 src_roi_empty,
  output logic [N_SRC-1:0]                 src_roi_re,
  input  logic [N_SRC*HEG2SFHIT_LEN-1:0]   src_hit,
  input  logic [N_SRC-1:0]                 src_hit_last,
  input  logic [N_SRC-1:0]                 src_hit_empty,
  output logic [N_SRC-1:0]                 src_hit_re,
  input  logic                             eng_ready,
  output logic [HEG2SFSLC_LEN-1:0]         eng_roi,
  output logic                             eng_roi_vld,
  output logic [HEG2SFHIT_LEN-1:0]         eng_hit,
  output logic                             eng_hit_vld,
  output logic                             eng_eof,
  input  logic                             eng_done,
  output logic [N_SRC-1:0]                 grant,
  output logic                             timeout_err,
  output logic [STAT_W-1:0]                stat_events,
  output logic [STAT_W-1:0]                stat_timeouts
);

  state_e                   state_q, state_d;
  logic [N_SRC-1:0]         grant_q, grant_d;
  logic [SRC_IDX_W-1:0]     gidx_q, gidx_d, last_q, last_d;
  logic [TO_W-1:0]          timer_q, timer_d;
  logic                     timer_exp, to_fire;
  logic [N_SRC-1:0]         arb_gnt;
  logic [SRC_IDX_W-1:0]     arb_idx;
  logic                     arb_vld;
  logic                     hit_avail, hit_last_g;
  logic [HEG2SFSLC_LEN-1:0] roi_head, eng_roi_q;
  logic [HEG2SFHIT_LEN-1:0] hit_head, eng_hit_q;
  logic                     eng_roi_vld_q, eng_hit_vld_q, eng_eof_q, timeout_err_q;

  lsf_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req_i  (~src_roi_empty),
    .last_i (last_q),
    .en_i   ((state_q == S_IDLE) && eng_ready),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  // One-hot grant selects the owner's FIFO heads and flags
  always_comb begin
    roi_head = '0;
    hit_head = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        roi_head = roi_head | src_roi[i*HEG2SFSLC_LEN +: HEG2SFSLC_LEN];
        hit_head = hit_head | src_hit[i*HEG2SFHIT_LEN +: HEG2SFHIT_LEN];
      end
    end
  end

  assign hit_avail  = |(grant_q & ~src_hit_empty);
  assign hit_last_g = |(grant_q & src_hit_last);
  assign timer_exp  = int'(timer_q) >= TIMEOUT - 1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    timer_d = timer_q;
    to_fire = 1'b0;
    unique case (state_q)
      S_IDLE: if (arb_vld) begin
        grant_d = arb_gnt;
        gidx_d  = arb_idx;
        state_d = S_ROI;
      end
      S_ROI: begin
        timer_d = '0;
        state_d = S_HITS;
      end
      S_HITS: begin
        if (hit_avail) begin
          timer_d = '0;
          if (hit_last_g) state_d = S_EOF;
        end else if (timer_exp) begin
          timer_d = TO_W'(TIMEOUT);
          to_fire = 1'b1;
          state_d = S_EOF;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      S_EOF: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || timer_exp) begin
          to_fire = !eng_done;
          timer_d = TO_W'(TIMEOUT);
          last_d  = gidx_q;
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_roi_re = '0;
    src_hit_re = '0;
    if (state_q == S_ROI)               src_roi_re = grant_q;
    if (state_q == S_HITS && hit_avail) src_hit_re = grant_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q       <= '0;
      gidx_q        <= '0;
      last_q        <= SRC_IDX_W'(N_SRC - 1);
      timer_q       <= '0;
      eng_roi_q     <= '0;
      eng_roi_vld_q <= 1'b0;
      eng_hit_q     <= '0;
      eng_hit_vld_q <= 1'b0;
      eng_eof_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      eng_roi_vld_q <= (state_q == S_ROI);
      eng_hit_vld_q <= |src_hit_re;
      eng_eof_q     <= (state_q == S_EOF);
      timeout_err_q <= to_fire;
      if (state_q == S_ROI) eng_roi_q <= roi_head;
      if (|src_hit_re)      eng_hit_q <= hit_head;
    end
  end

  assign grant       = grant_q;
  assign eng_roi     = eng_roi_q;
  assign eng_roi_vld = eng_roi_vld_q;
  assign eng_hit     = eng_hit_q;
  assign eng_hit_vld = eng_hit_vld_q;
  assign eng_eof     = eng_eof_q;
  assign timeout_err = timeout_err_q;

`ifdef LSF_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_ev_q, stat_to_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ev_q <= '0;
      stat_to_q <= '0;
    end else begin
      if (state_q == S_WAIT && eng_done) stat_ev_q <= stat_ev_q + STAT_W'(1);
      if (to_fire)                       stat_to_q <= stat_to_q + STAT_W'(1);
    end
  end

  assign stat_events   = stat_ev_q;
  assign stat_timeouts = stat_to_q;
`else
  assign stat_events   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_lsf_event_scheduler.sv
// Directed bench for lsf_event_scheduler: FIFO queue models, a simple engine responder and hand-computed expectations.
module tb_lsf_event_scheduler;
  import lsf_sched_pkg::*;

  localparam int N   = 3;
  localparam int SL  = HEG2SFSLC_LEN;
  localparam int HL  = HEG2SFHIT_LEN;
  localparam int TMO = 15;
`ifdef LSF_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [N*SL-1:0]   src_roi;
  logic [N-1:0]      src_roi_empty, src_roi_re;
  logic [N*HL-1:0]   src_hit;
  logic [N-1:0]      src_hit_last, src_hit_empty, src_hit_re;
  logic              eng_ready, eng_roi_vld, eng_hit_vld, eng_eof, eng_done, timeout_err;
  logic [SL-1:0]     eng_roi;
  logic [HL-1:0]     eng_hit;
  logic [N-1:0]      grant;
  logic [STAT_W-1:0] stat_events, stat_timeouts;

  lsf_event_scheduler #(.N_SRC(N), .TIMEOUT(TMO), .TO_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .src_roi       (src_roi),
    .src_roi_empty (src_roi_empty),
    .src_roi_re    (src_roi_re),
    .src_hit       (src_hit),
    .src_hit_last  (src_hit_last),
    .src_hit_empty (src_hit_empty),
    .src_hit_re    (src_hit_re),
    .eng_ready     (eng_ready),
    .eng_roi       (eng_roi),
    .eng_roi_vld   (eng_roi_vld),
    .eng_hit       (eng_hit),
    .eng_hit_vld   (eng_hit_vld),
    .eng_eof       (eng_eof),
    .eng_done      (eng_done),
    .grant         (grant),
    .timeout_err   (timeout_err),
    .stat_events   (stat_events),
    .stat_timeouts (stat_timeouts)
  );

  always #5 clock = ~clock;

  logic [SL-1:0] rq [N][$];
  logic [HL-1:0] hq [N][$];
  bit            hl [N][$];
  logic [N-1:0]  gq [$];
  logic [HL-1:0] oh [$];
  int            ohc [$];
  logic [N-1:0]  prev_grant;
  logic [HL-1:0] e2 [8];
  int cyc, checks, errors, foreign, eof_n, eof_cyc, to_n, to_cyc, dcnt;
  bit auto_eng;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int s = 0; s < N; s++) begin
      src_roi[s*SL +: SL] = (rq[s].size() > 0) ? rq[s][0] : '0;
      src_roi_empty[s]    = (rq[s].size() == 0);
      src_hit[s*HL +: HL] = (hq[s].size() > 0) ? hq[s][0] : '0;
      src_hit_last[s]     = (hl[s].size() > 0) ? hl[s][0] : 1'b0;
      src_hit_empty[s]    = (hq[s].size() == 0);
    end
  endtask

  task automatic push_hits(input int s, input int nh, input logic [HL-1:0] base, input bit with_last);
    for (int k = 0; k < nh; k++) begin
      hq[s].push_back(base + HL'(k));
      hl[s].push_back(with_last && (k == nh - 1));
    end
    refresh();
  endtask

  task automatic push_ev(input int s, input logic [SL-1:0] r, input int nh, input logic [HL-1:0] base, input bit with_last);
    rq[s].push_back(r);
    push_hits(s, nh, base, with_last);
  endtask

  task automatic clear_obs();
    gq.delete(); oh.delete(); ohc.delete();
    eof_n = 0; to_n = 0;
  endtask

  // Called at a negedge; returns at the next negedge with FIFO pops, monitor and engine updated.
  task automatic tick();
    logic [N-1:0] rr, rh;
    #1;
    rr = src_roi_re;
    rh = src_hit_re;
    @(posedge clock);
    #1;
    if (!reset) begin
      for (int s = 0; s < N; s++) begin
        if (rr[s] && rq[s].size() > 0) void'(rq[s].pop_front());
        if (rh[s] && hq[s].size() > 0) begin
          void'(hq[s].pop_front());
          void'(hl[s].pop_front());
        end
      end
    end
    refresh();
    cyc++;
    @(negedge clock);
    if (((src_roi_re | src_hit_re) & ~grant) != '0) foreign++;
    if (grant != '0 && prev_grant == '0) gq.push_back(grant);
    prev_grant = grant;
    if (eng_hit_vld) begin oh.push_back(eng_hit); ohc.push_back(cyc); end
    if (eng_eof) begin eof_n++; eof_cyc = cyc; end
    if (timeout_err) begin to_n++; to_cyc = cyc; end
    eng_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) eng_done = auto_eng;
    end
    if (eng_eof) dcnt = 2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; foreign = 0; cyc = 0; dcnt = 0; auto_eng = 0;
    eof_cyc = 0; to_cyc = 0; prev_grant = '0;
    reset = 1'b1; eng_ready = 1'b1; eng_done = 1'b0;
    src_roi = '0; src_hit = '0;
    refresh();
    clear_obs();
    @(negedge clock);
    tick();

    // Reset state
    chk("rst_grant", grant, 0);
    chk("rst_roi_re", src_roi_re, 0);
    chk("rst_hit_re", src_hit_re, 0);
    chk("rst_roi_vld", eng_roi_vld, 0);
    chk("rst_hit_vld", eng_hit_vld, 0);
    chk("rst_eof", eng_eof, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_eng_roi", eng_roi, 0);
    chk("rst_eng_hit", eng_hit, 0);
    chk("rst_stat_ev", stat_events, 0);
    chk("rst_stat_to", stat_timeouts, 0);

    // Basic event: src0, 1 ROI and 3 hits, manual engine done at cycle 10
    push_ev(0, SL'('hA0), 3, HL'('h10), 1'b1);
    reset = 1'b0; cyc = 0;
    chk("t1_c0_grant", grant, 0);
    tick();
    chk("t1_c1_roi_re", src_roi_re, 3'b001);
    chk("t1_c1_grant", grant, 3'b001);
    chk("t1_c1_roi_vld", eng_roi_vld, 0);
    tick();
    chk("t1_c2_roi_vld", eng_roi_vld, 1);
    chk("t1_c2_roi", eng_roi, 'hA0);
    chk("t1_c2_hit_re", src_hit_re, 3'b001);
    chk("t1_c2_roi_re", src_roi_re, 0);
    tick();
    chk("t1_c3_hit_vld", eng_hit_vld, 1);
    chk("t1_c3_hit", eng_hit, 'h10);
    tick();
    chk("t1_c4_hit", eng_hit, 'h11);
    tick();
    chk("t1_c5_hit", eng_hit, 'h12);
    chk("t1_c5_eof", eng_eof, 0);
    tick();
    chk("t1_c6_eof", eng_eof, 1);
    chk("t1_c6_hit_vld", eng_hit_vld, 0);
    repeat (4) tick();
    chk("t1_c10_grant", grant, 3'b001);
    eng_done = 1'b1;
    tick();
    chk("t1_c11_grant", grant, 0);
    chk("t1_c11_stat_ev", stat_events, STATS);
    chk("t1_eof_once", eof_n, 1);

    // Rotation: all sources request, 2 hits per event
    reset = 1'b1; tick(); tick();
    clear_obs(); foreign = 0; auto_eng = 1;
    push_ev(0, SL'('hB0), 2, HL'('h200), 1'b1);
    push_ev(0, SL'('hB1), 2, HL'('h210), 1'b1);
    push_ev(1, SL'('hB2), 2, HL'('h220), 1'b1);
    push_ev(2, SL'('hB3), 2, HL'('h230), 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 200 && !(gq.size() == 4 && grant == '0); i++) tick();
    chk("t2_done", (gq.size() == 4 && grant == '0), 1);
    chk("t2_g0", gq[0], 3'b001);
    chk("t2_g1", gq[1], 3'b010);
    chk("t2_g2", gq[2], 3'b100);
    chk("t2_g3", gq[3], 3'b001);
    e2 = '{HL'('h200), HL'('h201), HL'('h220), HL'('h221),
           HL'('h230), HL'('h231), HL'('h210), HL'('h211)};
    chk("t2_nhits", oh.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_hit%0d", i), oh[i], e2[i]);
    chk("t2_foreign", foreign, 0);
    chk("t2_no_timeout", to_n, 0);
    chk("t2_stat_ev", stat_events, STATS * 4);

    // Mid-event 12-cycle hit gap below the timeout, on src1
    clear_obs();
    push_ev(1, SL'('hC0), 2, HL'('h300), 1'b0);
    for (int i = 0; i < 50 && oh.size() < 2; i++) tick();
    chk("t3_first_two", oh.size(), 2);
    repeat (12) tick();
    push_hits(1, 2, HL'('h302), 1'b1);
    for (int i = 0; i < 60 && grant != '0; i++) tick();
    chk("t3_grant", gq[0], 3'b010);
    chk("t3_nhits", oh.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_hit%0d", i), oh[i], HL'('h300) + HL'(i));
    chk("t3_gap", ohc[2] - ohc[1], 13);
    chk("t3_no_timeout", to_n, 0);

    // Hit stall timeout on src2
    clear_obs();
    push_ev(2, SL'('hD0), 1, HL'('h400), 1'b0);
    for (int i = 0; i < 80 && !(gq.size() == 1 && grant == '0); i++) tick();
    chk("t4_grant", gq[0], 3'b100);
    chk("t4_hit", oh[0], 'h400);
    chk("t4_to_n", to_n, 1);
    chk("t4_to_delay", to_cyc - ohc[0], TMO);
    chk("t4_eof_after", eof_cyc - to_cyc, 1);
    chk("t4_stat_to", stat_timeouts, STATS);
    chk("t4_stat_ev", stat_events, STATS * 6);

    // No engine result: WAIT timeout, then next source granted
    clear_obs(); auto_eng = 0;
    push_ev(0, SL'('hE0), 1, HL'('h500), 1'b1);
    push_ev(1, SL'('hE1), 1, HL'('h510), 1'b1);
    for (int i = 0; i < 60 && to_n == 0; i++) tick();
    chk("t5_to_n", to_n, 1);
    chk("t5_wait_len", to_cyc - eof_cyc, TMO);
    chk("t5_grant_idle", grant, 0);
    tick();
    chk("t5_next_grant", grant, 3'b010);
    auto_eng = 1;
    for (int i = 0; i < 40 && grant != '0; i++) tick();
    chk("t5_single_pulse", to_n, 1);
    chk("t5_stat_to", stat_timeouts, STATS * 2);
    chk("t5_stat_ev", stat_events, STATS * 7);

    // Reset during HITS on src2
    clear_obs();
    push_ev(2, SL'('hF0), 3, HL'('h600), 1'b1);
    push_ev(0, SL'('hF1), 2, HL'('h610), 1'b1);
    for (int i = 0; i < 20 && oh.size() < 1; i++) tick();
    chk("t6_in_hits", grant, 3'b100);
    reset = 1'b1;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_hit_re", src_hit_re, 0);
    chk("t6_async_hit_vld", eng_hit_vld, 0);
    repeat (3) tick();
    chk("t6_no_eof", eof_n, 0);
    chk("t6_src2_hits_kept", hq[2].size(), 2);
    chk("t6_src0_roi_kept", rq[0].size(), 1);
    chk("t6_stat_ev", stat_events, 0);
    reset = 1'b0;
    tick();
    chk("t6_regrant_src0", grant, 3'b001);
    chk("all_foreign", foreign, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
